seq_serializer: RTL and testbench
=================================

SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 Parameter WIDTH, default 16, number of bits per parallel word (legal range 2..32).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low (rst==0 at a rising clk edge resets the block).
REQ-004 in_valid  input  1  upstream offers in_data this cycle.
REQ-005 in_ready  output  1  block can accept a word this cycle; a word transfers when in_valid && in_ready at a rising edge.
REQ-006 in_data  input  WIDTH  parallel word, serialized LSB first.
REQ-007 ser_en  input  1  downstream advance enable; one bit is consumed per edge with ser_en==1.
REQ-008 ser_out  output  1  current serial bit, for the bit-serial sequence detector downstream.
REQ-009 ser_valid  output  1  ser_out holds a real data bit.
REQ-010 ser_first  output  1  ser_out is bit 0 of a word.
REQ-011 ser_last  output  1  ser_out is bit WIDTH-1 of a word.
REQ-012 word_cnt  output  8  number of fully emitted words, modulo 256.

Function
REQ-013 Storage: one hold register (hold_data, hold_full) and one shift register with bit counter bit_idx (0..WIDTH-1).
REQ-014 in_ready SHALL equal !hold_full, driven from a register, with no combinational path from in_valid or ser_en.
REQ-015 On accept, in_data is written to hold_data and hold_full set at that edge.
REQ-016 FSM states: IDLE (ser_valid=0) and SHIFT (ser_valid=1); no other states.
REQ-017 IDLE -> SHIFT: at the first edge with hold_full==1; shift register <= hold_data, bit_idx <= 0, hold_full cleared at the same edge.
REQ-018 Latency: word accepted at edge k -> ser_valid=1 with bit 0 on ser_out after edge k+1.
REQ-019 In SHIFT with ser_en==1 and bit_idx<WIDTH-1: shift right by one, bit_idx increments.
REQ-020 In SHIFT with ser_en==1 and bit_idx==WIDTH-1: word_cnt increments (wrapping 255->0); if hold_full, reload from hold register with no bubble (stay SHIFT, bit_idx=0, hold_full cleared); else go to IDLE.
REQ-021 ser_en==0: ser_out, ser_first, ser_last, bit_idx, state frozen; hold register may still accept.
REQ-022 ser_en is ignored in IDLE; ser_out SHALL be 0 whenever ser_valid==0.
REQ-023 ser_first = SHIFT && bit_idx==0; ser_last = SHIFT && bit_idx==WIDTH-1.
REQ-024 Accept and hold drain in the same cycle cannot coincide (in_ready low while hold_full); a word is never dropped or duplicated.
REQ-025 Sustained throughput: one word per WIDTH enabled cycles with in_valid held high.

Reset
REQ-026 With rst==0: state=IDLE, hold_full=0, bit_idx=0, shift register=0, word_cnt=0; outputs in_ready=1 once rst returns to 1 (value during reset: 0), ser_out=0, ser_valid=0, ser_first=0, ser_last=0.
REQ-027 Reset mid-word discards the partial word and any held word; no word_cnt increment; the next accepted word begins at bit 0.

Verification
REQ-028 Reset: hold rst=0 two cycles with in_valid=1 -> no accept, all outputs 0, word_cnt=0.
REQ-029 Single word 16'h9799, ser_en=1 -> bits 1,0,0,1,1,0,0,1,1,1,1,0,1,0,0,1 on 16 consecutive cycles starting one cycle after accept; ser_first on cycle 1, ser_last on cycle 16; word_cnt=1; return to IDLE.
REQ-030 Back-to-back: two words offered continuously -> second accepted while first shifts, in_ready low until reload, 32 consecutive valid bits, no gap, word_cnt=2.
REQ-031 Stall: drop ser_en for 3 cycles at bit 5 -> ser_out/ser_first/ser_last unchanged during stall, remaining bits correct, total 19 cycles of ser_valid.
REQ-032 Mid-word reset at bit 7 -> outputs cleared at the next edge, word_cnt unchanged, next word serializes from bit 0.
REQ-033 Wrap: 257 words emitted -> word_cnt reads 1.

Source files
------------

// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial converter with a one-word hold buffer.
// Words are emitted LSB first, one bit per edge with ser_en high. A word
// waiting in the hold register is reloaded at the last bit with no bubble.
module seq_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic [7:0]       word_cnt
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             hold_full_q, hold_full_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic [7:0]       word_cnt_q, word_cnt_d;
  logic             accept;
  logic             at_last;
  logic             load;

  // Next-state: hold-buffer accept, shift/advance, word completion and reload.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    word_cnt_d  = word_cnt_q;
    load        = 1'b0;
    accept      = in_valid && in_ready_q;
    at_last     = (bit_idx_q == LAST_IDX);

    // in_ready_q is low whenever the hold register is full, so an accept
    // and a hold drain (load) can never happen on the same edge.
    if (accept) begin
      hold_data_d = in_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load = 1'b1;
        end
      end
      SHIFT: begin
        if (ser_en) begin
          if (!at_last) begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + 8'd1;
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d   = IDLE;
              shift_d   = '0;
              bit_idx_d = '0;
            end
          end
        end
      end
    endcase

    if (load) begin
      state_d     = SHIFT;
      shift_d     = hold_data_q;
      bit_idx_d   = '0;
      hold_full_d = 1'b0;
    end

    // Registered ready: mirrors the hold register's next occupancy.
    in_ready_d = !hold_full_d;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      in_ready_q  <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      in_ready_q  <= in_ready_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  // Output decode: serial bit and framing flags are gated by the SHIFT state.
  always_comb begin
    in_ready  = in_ready_q;
    ser_valid = (state_q == SHIFT);
    ser_out   = (state_q == SHIFT) && shift_q[0];
    ser_first = (state_q == SHIFT) && (bit_idx_q == '0);
    ser_last  = (state_q == SHIFT) && at_last;
    word_cnt  = word_cnt_q;
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed testbench for seq_serializer (WIDTH=16).
module tb_seq_serializer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        ser_en;
  logic        ser_out;
  logic        ser_valid;
  logic        ser_first;
  logic        ser_last;
  logic [7:0]  word_cnt;

  int errors = 0;
  int checks = 0;

  seq_serializer #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ser_en    (ser_en),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the full serial output bundle in one go.
  task automatic chk_ser(input string tag, input logic v, input logic b,
                         input logic f, input logic l);
    chk({tag, ".valid"}, {31'd0, ser_valid}, {31'd0, v});
    chk({tag, ".out"},   {31'd0, ser_out},   {31'd0, b});
    chk({tag, ".first"}, {31'd0, ser_first}, {31'd0, f});
    chk({tag, ".last"},  {31'd0, ser_last},  {31'd0, l});
  endtask

  logic [15:0] w;
  logic [15:0] wa;
  logic [15:0] wb;
  int          j;
  int          stall_cnt;
  int          acc;
  int          vcnt;
  logic        fire;
  logic        done;

  initial begin
    // ---- Reset held two cycles with in_valid high: nothing accepted ----
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    ser_en   = 1'b1;
    step();
    chk("rst0.in_ready", {31'd0, in_ready}, 32'd0);
    chk_ser("rst0", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst0.word_cnt", {24'd0, word_cnt}, 32'd0);
    step();
    chk("rst1.in_ready", {31'd0, in_ready}, 32'd0);
    chk_ser("rst1", 1'b0, 1'b0, 1'b0, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    chk("rel.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    step();
    chk_ser("rel.noacc", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rel.word_cnt", {24'd0, word_cnt}, 32'd0);

    // ---- Mid-word reset at bit 7, then a fresh word from bit 0 ----
    w        = 16'h6D2B;
    in_data  = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_ser($sformatf("mid.b%0d", i), 1'b1, w[i], i == 0, 1'b0);
    end
    rst = 1'b0;
    step();
    chk_ser("mid.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid.word_cnt", {24'd0, word_cnt}, 32'd0);
    rst = 1'b1;
    step();
    chk("mid.in_ready", {31'd0, in_ready}, 32'd1);
    w        = 16'h8001;
    in_data  = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk_ser($sformatf("post.b%0d", i), 1'b1, w[i], i == 0, i == 15);
    end
    step();
    chk_ser("post.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post.word_cnt", {24'd0, word_cnt}, 32'd1);
    $display("txn mid-word reset + word 8001 done, word_cnt=%0d", word_cnt);

    // ---- Single word 9799: bits 1,0,0,1,1,0,0,1,1,1,1,0,1,0,0,1 ----
    w        = 16'h9799;
    in_data  = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("one.in_ready", {31'd0, in_ready}, 32'd0);
    chk("one.lat", {31'd0, ser_valid}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk_ser($sformatf("one.b%0d", i), 1'b1, w[i], i == 0, i == 15);
    end
    step();
    chk_ser("one.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("one.word_cnt", {24'd0, word_cnt}, 32'd2);
    $display("txn single word 9799 done, word_cnt=%0d", word_cnt);

    // ---- Back-to-back: 32 contiguous bits, second word waits in hold ----
    wa       = 16'hA5C3;
    wb       = 16'h0F1E;
    in_data  = wa;
    in_valid = 1'b1;
    step();
    in_data = wb;
    chk("b2b.in_ready0", {31'd0, in_ready}, 32'd0);
    for (int c = 0; c < 32; c++) begin
      step();
      if (c == 1) in_valid = 1'b0;
      chk_ser($sformatf("b2b.c%0d", c), 1'b1, (c < 16) ? wa[c % 16] : wb[c % 16],
              (c % 16) == 0, (c % 16) == 15);
      chk($sformatf("b2b.rdy%0d", c), {31'd0, in_ready},
          {31'd0, (c == 0 || c >= 16)});
    end
    step();
    chk_ser("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b.word_cnt", {24'd0, word_cnt}, 32'd4);
    $display("txn back-to-back A5C3/0F1E done, word_cnt=%0d", word_cnt);

    // ---- Stall: ser_en low for 3 edges while bit 5 is showing ----
    w         = 16'h3C5A;
    in_data   = w;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    j         = 0;
    stall_cnt = 0;
    vcnt      = 0;
    for (int c = 0; c < 19; c++) begin
      step();
      if (ser_valid) vcnt++;
      chk_ser($sformatf("stall.c%0d", c), 1'b1, w[j], j == 0, j == 15);
      if (j == 5 && stall_cnt < 3) begin
        ser_en = 1'b0;
        stall_cnt++;
      end else begin
        ser_en = 1'b1;
        j++;
      end
    end
    step();
    chk_ser("stall.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall.vcnt", vcnt, 32'd19);
    chk("stall.word_cnt", {24'd0, word_cnt}, 32'd5);
    $display("txn stall word 3C5A done, valid cycles=%0d", vcnt);

    // ---- Wrap: reset, then 257 words streamed back to back ----
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("wrap.start_cnt", {24'd0, word_cnt}, 32'd0);
    acc      = 0;
    vcnt     = 0;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0001;
    for (int t = 0; t < 6000 && !done; t++) begin
      fire = in_valid && in_ready;
      step();
      if (fire) begin
        acc++;
        in_data = in_data + 16'h0101;
        if (acc == 257) in_valid = 1'b0;
      end
      if (ser_valid) vcnt++;
      else if (acc == 257 && vcnt > 0) done = 1'b1;
    end
    chk("wrap.done", {31'd0, done}, 32'd1);
    chk("wrap.vcnt", vcnt, 32'd4112);
    chk("wrap.word_cnt", {24'd0, word_cnt}, 32'd1);
    $display("txn wrap 257 words: valid cycles=%0d word_cnt=%0d", vcnt, word_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
